// File: rtl/input_sequence_check.sv
`default_nettype none
// ============================================================================
// Module      : input_sequence_check
// Description : Checks a 4-step player button sequence against a latched
//               8-bit pattern, one press and release per step. Define
//               SIMON_TIMEOUT_EN to add a per-press timeout of
//               TIMEOUT_CYCLES clock cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module input_sequence_check #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] sequence_in,
    input  logic       begin_signal,
    input  logic [3:0] buttons,
    output logic [7:0] entered,
    output logic [2:0] step_count,
    output logic       busy,
    output logic       done,
    output logic       match,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_WAIT_PRESS   = 2'd1,
        S_WAIT_RELEASE = 2'd2,
        S_DONE         = 2'd3
    } state_t;

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 32'h000F_FFFF)) begin : g_param_check
        $error("TIMEOUT_CYCLES must be within 2..2^20-1");
    end

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_seq;
    logic [7:0] w_seq_next;
    logic [7:0] r_entered;
    logic [7:0] w_entered_next;
    logic [2:0] r_step;
    logic [2:0] w_step_next;
    logic       r_match;
    logic       w_match_next;
    logic       r_begin_d;

    logic       w_begin_rise;
    logic       w_one_hot;
    logic [1:0] w_code;
    logic [2:0] w_shift;
    logic [1:0] w_exp_code;

`ifdef SIMON_TIMEOUT_EN
    localparam logic [19:0] c_timer_last = 20'(TIMEOUT_CYCLES - 1);

    logic [19:0] r_timer;
    logic [19:0] w_timer_next;
    logic        r_timeout;
    logic        w_timeout_next;
`endif

    assign w_begin_rise = begin_signal & ~r_begin_d;
    assign w_one_hot    = (buttons != 4'd0) && ((buttons & (buttons - 4'd1)) == 4'd0);

    // Step k lives at bit offset 6-2k; for k in 0..3 that is {~k, 0}.
    assign w_shift    = {~r_step[1:0], 1'b0};
    assign w_exp_code = 2'(r_seq >> w_shift);

    always_comb begin
        w_code = 2'd0;
        case (buttons)
            4'b0010: w_code = 2'd1;
            4'b0100: w_code = 2'd2;
            4'b1000: w_code = 2'd3;
            default: w_code = 2'd0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_seq     <= 8'd0;
            r_entered <= 8'd0;
            r_step    <= 3'd0;
            r_match   <= 1'b0;
            r_begin_d <= 1'b1;
`ifdef SIMON_TIMEOUT_EN
            r_timer   <= 20'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_seq     <= w_seq_next;
            r_entered <= w_entered_next;
            r_step    <= w_step_next;
            r_match   <= w_match_next;
            r_begin_d <= begin_signal;
`ifdef SIMON_TIMEOUT_EN
            r_timer   <= w_timer_next;
            r_timeout <= w_timeout_next;
`endif
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_seq_next     = r_seq;
        w_entered_next = r_entered;
        w_step_next    = r_step;
        w_match_next   = r_match;
`ifdef SIMON_TIMEOUT_EN
        w_timer_next   = r_timer;
        w_timeout_next = r_timeout;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_begin_rise) begin
                    w_state_next   = S_WAIT_PRESS;
                    w_seq_next     = sequence_in;
                    w_entered_next = 8'd0;
                    w_step_next    = 3'd0;
                    w_match_next   = 1'b0;
`ifdef SIMON_TIMEOUT_EN
                    w_timer_next   = 20'd0;
                    w_timeout_next = 1'b0;
`endif
                end
            end
            S_WAIT_PRESS: begin
                if (!begin_signal) begin
                    w_state_next = S_IDLE;
                    w_match_next = 1'b0;
                end else if (w_one_hot) begin
                    // A valid press beats a same-cycle timer expiry.
                    w_entered_next = r_entered | (8'(w_code) << w_shift);
                    w_step_next    = r_step + 3'd1;
                    if (w_code == w_exp_code) begin
                        w_state_next = S_WAIT_RELEASE;
                    end else begin
                        w_state_next = S_DONE;
                        w_match_next = 1'b0;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (r_timer == c_timer_last) begin
                    w_state_next   = S_DONE;
                    w_match_next   = 1'b0;
                    w_timeout_next = 1'b1;
                end else begin
                    w_timer_next = r_timer + 20'd1;
                end
`endif
            end
            S_WAIT_RELEASE: begin
                if (!begin_signal) begin
                    w_state_next = S_IDLE;
                    w_match_next = 1'b0;
                end else if (buttons == 4'd0) begin
                    if (r_step == 3'd4) begin
                        w_state_next = S_DONE;
                        w_match_next = 1'b1;
                    end else begin
                        w_state_next = S_WAIT_PRESS;
`ifdef SIMON_TIMEOUT_EN
                        w_timer_next = 20'd0;
`endif
                    end
                end
            end
            S_DONE: begin
                if (!begin_signal) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign entered    = r_entered;
    assign step_count = r_step;
    assign busy       = (r_state == S_WAIT_PRESS) || (r_state == S_WAIT_RELEASE);
    assign done       = (r_state == S_DONE);
    assign match      = r_match;
`ifdef SIMON_TIMEOUT_EN
    assign timeout    = r_timeout;
`else
    assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_sequence_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_sequence_check
// Description : Self-checking bench for input_sequence_check with directed
//               cases and randomized rounds against a round-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_sequence_check;

    localparam int unsigned TIMEOUT_CYCLES = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] sequence_in = 8'd0;
    logic       begin_signal = 1'b1;
    logic [3:0] buttons = 4'd0;
    logic [7:0] entered;
    logic [2:0] step_count;
    logic       busy;
    logic       done;
    logic       match;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Round-level model: latched pattern, captured directions, press count.
    logic [7:0] m_seq;
    logic [7:0] m_entered;
    int         m_count;

    input_sequence_check #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dut (
        .clock       (clock),
        .resetn      (resetn),
        .sequence_in (sequence_in),
        .begin_signal(begin_signal),
        .buttons     (buttons),
        .entered     (entered),
        .step_count  (step_count),
        .busy        (busy),
        .done        (done),
        .match       (match),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [1:0] step_code(input logic [7:0] seq, input int k);
        return 2'((seq / (1 << (6 - 2 * k))) % 4);
    endfunction

    task automatic start_round(input logic [7:0] seq);
        begin_signal = 1'b0;
        buttons      = 4'd0;
        tick();
        sequence_in  = seq;
        begin_signal = 1'b1;
        tick();
        m_seq     = seq;
        m_entered = 8'd0;
        m_count   = 0;
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_step", 32'(step_count), 0);
        check("start_entered", 32'(entered), 0);
    endtask

    task automatic end_round();
        begin_signal = 1'b0;
        buttons      = 4'd0;
        tick();
        check("end_busy", 32'(busy), 0);
        check("end_done", 32'(done), 0);
    endtask

    // One press followed by a release; ended=1 once the round is decided.
    task automatic press(input logic [1:0] code, input int hold, output bit ended);
        bit wrong;
        wrong     = (code != step_code(m_seq, m_count));
        m_entered = m_entered + 8'(int'(code) * (1 << (6 - 2 * m_count)));
        m_count++;
        buttons = 4'(1 << code);
        tick();
        check("press_step", 32'(step_count), 32'(m_count));
        check("press_entered", 32'(entered), 32'(m_entered));
        if (wrong) begin
            check("early_fail_done", 32'(done), 1);
            check("early_fail_match", 32'(match), 0);
            check("early_fail_timeout", 32'(timeout), 0);
        end else begin
            check("press_busy", 32'(busy), 1);
        end
        repeat (hold) tick();
        check("hold_step", 32'(step_count), 32'(m_count));
        buttons = 4'd0;
        tick();
        ended = wrong || (m_count == 4);
        check("release_done", 32'(done), 32'(ended));
        check("release_busy", 32'(busy), 32'(!ended));
        if (ended) begin
            check("release_match", 32'(match), 32'(!wrong));
            check("release_timeout", 32'(timeout), 0);
        end
    endtask

    initial begin
        bit         ended;
        logic [3:0] bad_pat [12] = '{4'h0, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA,
                                     4'hC, 4'h7, 4'hB, 4'hD, 4'hE, 4'hF};

        // Reset with begin held high: idle outputs, no spurious start.
        tick();
        check("rst_entered", 32'(entered), 0);
        check("rst_step", 32'(step_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_match", 32'(match), 0);
        check("rst_timeout", 32'(timeout), 0);
        resetn = 1'b1;
        repeat (3) tick();
        check("begin_held_no_start", 32'(busy), 0);

        // Full correct round.
        start_round(8'b00_01_10_11);
        for (int k = 0; k < 4; k++) begin
            press(2'(k), 0, ended);
        end
        check("full_match", 32'(match), 1);
        check("full_entered", 32'(entered), 32'h1B);
        check("full_step", 32'(step_count), 4);
        end_round();

        // Wrong second press; DONE holds while begin stays high.
        start_round(8'b00_01_10_11);
        press(2'd0, 0, ended);
        press(2'd3, 0, ended);
        repeat (2) tick();
        check("fail_hold_done", 32'(done), 1);
        check("fail_hold_step", 32'(step_count), 2);
        check("fail_hold_entered", 32'(entered), 32'h30);
        end_round();

        // Multi-bit presses ignored, then a single bit accepted; then abort.
        start_round(8'b00_01_10_11);
        buttons = 4'b0011;
        tick();
        check("multi_ignored_step", 32'(step_count), 0);
        buttons = 4'b1111;
        repeat (2) tick();
        check("all_ignored_step", 32'(step_count), 0);
        check("all_ignored_busy", 32'(busy), 1);
        press(2'd0, 1, ended);
        begin_signal = 1'b0;
        tick();
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_match", 32'(match), 0);
        start_round(8'b11_10_01_00);

        // Asynchronous reset mid-round.
        press(2'd3, 0, ended);
        press(2'd2, 0, ended);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_entered", 32'(entered), 0);
        check("async_rst_step", 32'(step_count), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_done", 32'(done), 0);
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        check("post_rst_no_start", 32'(busy), 0);

`ifdef SIMON_TIMEOUT_EN
        // No press: timeout exactly TIMEOUT_CYCLES edges after entry.
        start_round(8'h1B);
        repeat (TIMEOUT_CYCLES - 1) tick();
        check("pre_timeout_done", 32'(done), 0);
        tick();
        check("timeout_done", 32'(done), 1);
        check("timeout_flag", 32'(timeout), 1);
        check("timeout_match", 32'(match), 0);
        end_round();
        // Press arriving in the expiry cycle wins.
        start_round(8'h1B);
        repeat (TIMEOUT_CYCLES - 1) tick();
        press(2'd0, 0, ended);
        check("press_wins_timeout", 32'(timeout), 0);
        end_round();
`else
        start_round(8'h1B);
        repeat (50) tick();
        check("no_timeout_busy", 32'(busy), 1);
        check("no_timeout_flag", 32'(timeout), 0);
        end_round();
`endif

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            start_round(8'($urandom));
            ended = 1'b0;
            while (!ended) begin
                repeat ($urandom_range(0, 3)) begin
                    buttons     = bad_pat[$urandom_range(0, 11)];
                    sequence_in = 8'($urandom);
                    tick();
                    check("rand_ignore_step", 32'(step_count), 32'(m_count));
                end
                if ($urandom_range(0, 4) == 0)
                    press(2'($urandom), $urandom_range(0, 2), ended);
                else
                    press(step_code(m_seq, m_count), $urandom_range(0, 2), ended);
            end
            repeat ($urandom_range(1, 3)) tick();
            check("rand_done_hold", 32'(done), 1);
            check("rand_entered_hold", 32'(entered), 32'(m_entered));
            end_round();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
